// File: rtl/alu32_if.sv
// Operand/select and result/flag bundle between the datapath and alu32.
interface alu32_if;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [2:0]  sel;
  logic [31:0] res;
  logic        z;
  logic        c;
  logic        v;

  modport master (output opA, output opB, output sel,
                  input  res, input  z,   input  c, input v);
  modport slave  (input  opA, input  opB, input  sel,
                  output res, output z,   output c, output v);
endinterface

// File: rtl/alu32.sv
// 32-bit ALU: add/sub/and/or/not with zero, carry and signed-overflow flags,
// all registered one clock after the operands are sampled.
module alu32 (
  input  logic    clk,
  input  logic    rst,
  alu32_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100
  } op_e;

  logic [31:0] b_eff;
  logic        cin;
  logic [32:0] sum;

  logic [31:0] res_d, res_q;
  logic        z_d, z_q;
  logic        c_d, c_q;
  logic        v_d, v_q;

  // One shared 33-bit adder; SUB feeds ~opB with carry-in 1.
  always_comb begin
    cin   = (bus.sel == OP_SUB);
    b_eff = cin ? ~bus.opB : bus.opB;
    sum   = {1'b0, bus.opA} + {1'b0, b_eff} + {32'd0, cin};
  end

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (bus.sel)
      OP_ADD, OP_SUB: begin
        res_d = sum[31:0];
        c_d   = sum[32];
        // Overflow when the effective addends agree in sign but the sum does not.
        v_d   = (bus.opA[31] == b_eff[31]) && (sum[31] != bus.opA[31]);
      end
      OP_AND:  res_d = bus.opA & bus.opB;
      OP_OR:   res_d = bus.opA | bus.opB;
      OP_NOT:  res_d = ~bus.opA;
      default: res_d = '0;
    endcase
    z_d = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      z_q   <= 1'b1;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      res_q <= res_d;
      z_q   <= z_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  assign bus.res = res_q;
  assign bus.z   = z_q;
  assign bus.c   = c_q;
  assign bus.v   = v_q;

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: driver pushes model results, monitor pops and compares.
module tb_alu32;

  logic clk;
  logic rst;
  alu32_if bus ();

  alu32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   stim_done = 0;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] s, input logic r, input string name);
    exp_t e;
    longint unsigned u;
    longint sg;
    e.res = 32'd0; e.c = 1'b0; e.v = 1'b0; e.name = name;
    if (!r) begin
      case (s)
        3'd0: begin
          u     = longint'(a) + longint'(b);
          e.res = u[31:0];
          e.c   = u[32];
          sg    = longint'(int'(a)) + longint'(int'(b));
          e.v   = (sg > SMAX) || (sg < SMIN);
        end
        3'd1: begin
          e.res = a - b;
          e.c   = (a >= b);
          sg    = longint'(int'(a)) - longint'(int'(b));
          e.v   = (sg > SMAX) || (sg < SMIN);
        end
        3'd2: e.res = a & b;
        3'd3: e.res = a | b;
        3'd4: e.res = ~a;
        default: e.res = 32'd0;
      endcase
    end
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s, input logic r, input string name);
    bus.opA = a;
    bus.opB = b;
    bus.sel = s;
    rst     = r;
    @(posedge clk);
    exp_q.push_back(model(a, b, s, r, name));
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total_cnt++;
      if ({bus.res, bus.z, bus.c, bus.v} === {e.res, e.z, e.c, e.v})
        pass_cnt++;
      else
        $display("FAIL %s: got res=%h z=%b c=%b v=%b, expected res=%h z=%b c=%b v=%b",
                 e.name, bus.res, bus.z, bus.c, bus.v, e.res, e.z, e.c, e.v);
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  s;
    logic        r;
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;

    bus.opA = '0; bus.opB = '0; bus.sel = '0; rst = 1'b1;

    step(32'hFFFF_FFFF, 32'h1, 3'b000, 1'b1, "reset_0");
    step(32'hFFFF_FFFF, 32'h1, 3'b000, 1'b1, "reset_1");
    step(32'hFFFF_FFFF, 32'h1, 3'b000, 1'b0, "release_add");

    step(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, "add_ovf_pos");
    step(32'h8000_0000, 32'h8000_0000, 3'b000, 1'b0, "add_ovf_neg");
    step(32'h0000_0005, 32'h0000_0003, 3'b000, 1'b0, "add_small");
    step(32'h0000_0005, 32'h0000_0005, 3'b001, 1'b0, "sub_zero");
    step(32'h0000_0003, 32'h0000_0005, 3'b001, 1'b0, "sub_borrow");
    step(32'h8000_0000, 32'h0000_0001, 3'b001, 1'b0, "sub_ovf");
    step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 1'b0, "and");
    step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 1'b0, "or");
    step(32'hFFFF_FFFF, 32'h1234_5678, 3'b100, 1'b0, "not_all_ones");
    step(32'h1357_9BDF, 32'hDEAD_BEEF, 3'b101, 1'b0, "reserved_101");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 1'b0, "reserved_110");
    step(32'h0000_0001, 32'h8000_0000, 3'b111, 1'b0, "reserved_111");

    // Back-to-back across all opcodes, reset dropped into the middle.
    step(32'h0000_0010, 32'h0000_0020, 3'b000, 1'b0, "b2b_add");
    step(32'h0000_0010, 32'h0000_0020, 3'b001, 1'b0, "b2b_sub");
    step(32'hAAAA_AAAA, 32'h5555_5555, 3'b010, 1'b0, "b2b_and");
    step(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b1, "b2b_rst");
    step(32'hAAAA_AAAA, 32'h5555_5555, 3'b011, 1'b0, "b2b_or_after_rst");
    step(32'h0000_0000, 32'h0000_0000, 3'b100, 1'b0, "b2b_not");

    for (int i = 0; i < 400; i++) begin
      a = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 9) == 0) b = a;
      s = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 39) == 0);
      step(a, b, s, r, "random");
    end

    stim_done = 1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d results still pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
